alu_mc: RTL and testbench

- Parametrised successor to the simple CPU's add/sub ALU.
- Keeps the bus-driven datapath: operand register A loads from the bus, and result register G is written on command.
- Generalises operand width and adds logic, compare and pass operations, plus status flags.
- Adds a multi-cycle shift-add multiplier with a busy/done handshake toward the control FSM.

---
 rtl/alu_mc.sv | 208 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Bus-driven ALU with W-bit datapath. Operand register A loads
//            from the bus; result register G is written on command. Supports
//            ADD/SUB/AND/OR/XOR/SLT/PASS in one cycle and an unsigned,
//            truncated shift-add multiply that takes W cycles with a
//            busy/done handshake.
// Ports    : clock    - system clock, rising edge
//            resetn   - asynchronous active-low reset
//            buswires - shared data bus (operand B, source for A)
//            ain      - load A from buswires at next edge
//            gin      - execute op / start multiply
//            op       - operation select (110 = MUL)
//            aluout   - register G
//            flag_z/n/c/v - status flags of the last written result
//            busy     - multiply in progress
//            done     - one-cycle pulse when a multiply result lands in G
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] buswires,
  input  logic         ain,
  input  logic         gin,
  input  logic [2:0]   op,
  output logic [W-1:0] aluout,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_OR   = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_SLT  = 3'b101;
  localparam logic [2:0] c_OP_MUL  = 3'b110;
  localparam logic [2:0] c_OP_PASS = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_g;
  logic           r_z, r_n, r_c, r_v;
  logic           r_done;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;

  logic [W:0]     w_sum;
  logic [W:0]     w_dif;
  logic [W-1:0]   w_res;
  logic           w_c, w_v;
  logic [W-1:0]   w_acc_nxt;
  logic           w_mul_start;
  logic           w_mul_last;
  logic           w_alu_wr;

  // --------------------------------------------------------------------------
  // Single-cycle ALU. ADD/SUB are W+1 bits so the top bit yields carry or
  // borrow directly; SUB's carry flag is the inverted borrow.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum = {1'b0, r_a} + {1'b0, buswires};
    w_dif = {1'b0, r_a} - {1'b0, buswires};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      c_OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_a[W-1] == buswires[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      c_OP_SUB: begin
        w_res = w_dif[W-1:0];
        w_c   = ~w_dif[W];
        // B's sign is effectively inverted for subtraction
        w_v   = (r_a[W-1] != buswires[W-1]) && (w_dif[W-1] != r_a[W-1]);
      end
      c_OP_AND:  w_res = r_a & buswires;
      c_OP_OR:   w_res = r_a | buswires;
      c_OP_XOR:  w_res = r_a ^ buswires;
      c_OP_SLT:  w_res = {{(W-1){1'b0}}, ($signed(r_a) < $signed(buswires))};
      c_OP_PASS: w_res = buswires;
      default:   w_res = '0;
    endcase
  end

  // One shift-add step; on the final step this is the truncated product.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // --------------------------------------------------------------------------
  // Control FSM: gin is only honoured in IDLE, so anything arriving while a
  // multiply runs (including the edge where it finishes) is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_mul_last  = 1'b0;
    w_alu_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (gin) begin
          if (op == c_OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_alu_wr = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(1)) begin
          w_mul_last  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_a      <= '0;
      r_g      <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      // A is loaded regardless of busy; the multiplier works on its own copies.
      if (ain) begin
        r_a <= buswires;
      end

      r_done <= w_mul_last;

      if (w_mul_start) begin
        r_mcand  <= r_a;
        r_mplier <= buswires;
        r_acc    <= '0;
        r_cnt    <= CW'(W);
      end else if (r_state == S_RUN) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= {r_mcand[W-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[W-1:1]};
        r_cnt    <= r_cnt - CW'(1);
      end

      if (w_mul_last) begin
        r_g <= w_acc_nxt;
        r_z <= (w_acc_nxt == '0);
        r_n <= w_acc_nxt[W-1];
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_alu_wr) begin
        r_g <= w_res;
        r_z <= (w_res == '0);
        r_n <= w_res[W-1];
        r_c <= w_c;
        r_v <= w_v;
      end
    end
  end

  assign aluout = r_g;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;
  assign busy   = (r_state == S_RUN);
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc. Directed cases for arithmetic
//            corners, multiply timing, gin/ain during busy and asynchronous
//            reset, plus randomized ops against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  localparam int W = 16;
  localparam logic [2:0] c_ADD  = 3'b000;
  localparam logic [2:0] c_SUB  = 3'b001;
  localparam logic [2:0] c_SLT  = 3'b101;
  localparam logic [2:0] c_MUL  = 3'b110;

  logic         clock;
  logic         resetn;
  logic [W-1:0] buswires;
  logic         ain;
  logic         gin;
  logic [2:0]   op;
  logic [W-1:0] aluout;
  logic         flag_z, flag_n, flag_c, flag_v;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [W-1:0] m_a;
  logic [W-1:0] m_g;
  logic [3:0]   m_f;   // {z,n,c,v}

  alu_mc #(.W(W)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .buswires (buswires),
    .ain      (ain),
    .gin      (gin),
    .op       (op),
    .aluout   (aluout),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {z,n,c,v,result}
  function automatic logic [W+3:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] o);
    int           sa, sb, s;
    longint       u;
    logic [W-1:0] r;
    logic         c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    case (o)
      3'd0: begin
        u = longint'(a) + longint'(b);
        r = u[W-1:0];
        c = (u >= (64'd1 << W));
        s = sa + sb;
        v = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
      end
      3'd1: begin
        u = longint'(a) - longint'(b);
        r = u[W-1:0];
        c = (a >= b);
        s = sa - sb;
        v = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? W'(1) : W'(0);
      3'd6: begin
        u = longint'(a) * longint'(b);
        r = u[W-1:0];
      end
      default: r = b;
    endcase
    return {(r == 0), r[W-1], c, v, r};
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_a(input logic [W-1:0] v);
    ain      = 1'b1;
    buswires = v;
    cycle();
    ain      = 1'b0;
    m_a      = v;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_g"}, aluout, m_g);
    check({tag, "_flags"}, {flag_z, flag_n, flag_c, flag_v}, m_f);
  endtask

  // Issue one op; for MUL, waits (bounded) for done and checks latency.
  task automatic exec(input logic [W-1:0] b, input logic [2:0] o, input string tag);
    logic [W+3:0] e;
    int           n;
    e        = model_op(m_a, b, o);
    gin      = 1'b1;
    buswires = b;
    op       = o;
    cycle();
    gin      = 1'b0;
    if (o != c_MUL) begin
      m_g = e[W-1:0];
      m_f = e[W+3:W];
      check_result(tag);
      check({tag, "_bd"}, {busy, done}, 2'b00);
    end else begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_hold"}, aluout, m_g);
      n = 0;
      while (!done && n < W + 4) begin
        if (n == W - 1) check({tag, "_holdlate"}, {busy, aluout}, {1'b1, m_g});
        cycle();
        n++;
      end
      check({tag, "_lat"}, n, W);
      m_g = e[W-1:0];
      m_f = e[W+3:W];
      check_result(tag);
      check({tag, "_busyoff"}, busy, 1'b0);
    end
  endtask

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int dcount;
    resetn   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    op       = 3'b000;
    buswires = '0;
    m_a = '0; m_g = '0; m_f = '0;
    #12;
    check("reset_g", aluout, 16'h0000);
    check("reset_misc", {flag_z, flag_n, flag_c, flag_v, busy, done}, 6'b0);
    cycle();
    resetn = 1'b1;
    cycle();

    // Signed overflow on ADD
    load_a(16'h7FFF);
    exec(16'h0001, c_ADD, "add_ovf");
    check("add_ovf_abs", {aluout, flag_z, flag_n, flag_c, flag_v}, {16'h8000, 4'b0101});
    // Equal SUB -> zero, no borrow
    load_a(16'h0005);
    exec(16'h0005, c_SUB, "sub_eq");
    check("sub_eq_abs", {aluout, flag_z, flag_c, flag_v}, {16'h0000, 3'b110});
    load_a(16'h0003);
    exec(16'h0005, c_SLT, "slt");
    check("slt_abs", {aluout, flag_c}, {16'h0001, 1'b0});

    // Multiply 300 x 7, then an ADD in the done cycle is accepted
    load_a(16'h012C);
    exec(16'h0007, c_MUL, "mul1");
    check("mul1_abs", {aluout, flag_z, flag_n, done}, {16'h0834, 3'b001});
    exec(16'h0001, c_ADD, "after_done");
    // Truncated product
    load_a(16'h0100);
    exec(16'h0100, c_MUL, "mul_trunc");
    check("mul_trunc_abs", {aluout, flag_z, flag_c, flag_v}, {16'h0000, 3'b100});

    // ain and gin on the same edge: op uses the old A
    load_a(16'h0010);
    ain = 1'b1; gin = 1'b1; buswires = 16'h0001; op = c_ADD;
    cycle();
    ain = 1'b0; gin = 1'b0;
    m_g = 16'h0011; m_f = 4'b0000; m_a = 16'h0001;
    check_result("same_edge");
    exec(16'h0000, c_ADD, "same_edge_newa");

    // gin and ain during a multiply of 3 x 5
    load_a(16'h0003);
    gin = 1'b1; buswires = 16'h0005; op = c_MUL;
    cycle();
    gin = 1'b0;
    repeat (3) cycle();
    gin = 1'b1; ain = 1'b1; op = c_ADD; buswires = 16'hFFFF;
    cycle();
    gin = 1'b0; ain = 1'b0;
    m_a = 16'hFFFF;
    check("busy_gin_ignored", {busy, aluout}, {1'b1, m_g});
    n = 0;
    while (!done && n < W + 4) begin cycle(); n++; end
    check("busy_mul_lat", n, W - 4);
    m_g = 16'h000F; m_f = 4'b0000;
    check_result("busy_mul");
    exec(16'h0000, c_ADD, "busy_ain_kept");

    // Asynchronous reset in the middle of a multiply
    load_a(16'h012C);
    gin = 1'b1; buswires = 16'h0007; op = c_MUL;
    cycle();
    gin = 1'b0;
    repeat (5) cycle();
    #2 resetn = 1'b0;
    #1;
    check("arst_g", aluout, 16'h0000);
    check("arst_misc", {flag_z, flag_n, flag_c, flag_v, busy, done}, 6'b0);
    m_a = '0; m_g = '0; m_f = '0;
    cycle();
    cycle();
    resetn = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (done || busy) dcount++;
    end
    check("arst_no_done", dcount, 0);
    load_a(16'h0002);
    exec(16'h0002, c_ADD, "post_reset_add");

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) load_a(rv());
      exec(rv(), 3'($urandom_range(0, 7)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
